// File: rtl/fast_square_packer.sv
// Packs sliced I/Q shift-register words into the RX FIFO, framed per
// frequency step with a marker/index header; absorbs FIFO backpressure.
module fast_square_packer #(
    parameter logic [15:0] MARKER = 16'h8000,
    parameter int          CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_strobe,
    input  logic             record,
    input  logic             freq_step,
    input  logic [15:0]      i_word,
    input  logic [15:0]      q_word,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [15:0]      fifo_data,
    output logic [CNT_W-1:0] step_index,
    output logic [CNT_W-1:0] overrun_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_M,
        HDR_X,
        RUN,
        EMIT_I,
        EMIT_Q
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [15:0]      hold_i_q, hold_i_d;
    logic [15:0]      hold_q_q, hold_q_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic cap_en;
    logic wrap;
    logic q_done;

    function automatic logic [15:0] esc(input logic [15:0] w);
        return (w == MARKER) ? (MARKER | 16'h0001) : w;
    endfunction

    assign step_index    = step_q;
    assign overrun_count = ovr_q;

    always_comb begin
        fifo_wr   = 1'b0;
        fifo_data = 16'h0000;
        unique case (state_q)
            HDR_M: begin
                fifo_wr   = !fifo_full;
                fifo_data = MARKER;
            end
            HDR_X: begin
                fifo_wr   = !fifo_full;
                fifo_data = 16'(step_q);
            end
            EMIT_I: begin
                fifo_wr   = !fifo_full;
                fifo_data = esc(hold_i_q);
            end
            EMIT_Q: begin
                fifo_wr   = !fifo_full;
                fifo_data = esc(hold_q_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        step_d   = step_q;
        ovr_d    = ovr_q;

        cap_en = (state_q != IDLE) && record && sample_strobe && !freq_step;
        wrap   = cap_en && (cnt_q == 4'd15);
        q_done = (state_q == EMIT_Q) && fifo_wr;

        if (cap_en)
            cnt_d = cnt_q + 4'd1;
        else if (!record)
            cnt_d = 4'd0;

        unique case (state_q)
            IDLE: begin
                if (record) begin
                    state_d = HDR_M;
                    cnt_d   = sample_strobe ? 4'd1 : 4'd0;
                    pend_d  = 1'b0;
                end
            end
            HDR_M: if (fifo_wr) state_d = HDR_X;
            HDR_X: if (fifo_wr) state_d = RUN;
            RUN: begin
                if (pend_q || wrap)
                    state_d = EMIT_I;
                else if (!record)
                    state_d = IDLE;
            end
            EMIT_I: if (fifo_wr) state_d = EMIT_Q;
            EMIT_Q: begin
                if (fifo_wr) begin
                    state_d = RUN;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pair finishing while the hold register is still owed is dropped
        if (wrap) begin
            if (pend_q && !q_done) begin
                if (!(&ovr_q))
                    ovr_d = ovr_q + CNT_W'(1);
            end else begin
                pend_d   = 1'b1;
                hold_i_d = i_word;
                hold_q_d = q_word;
            end
        end

        if (freq_step) begin
            step_d = step_q + CNT_W'(1);
            if (record) begin
                state_d = HDR_M;
                cnt_d   = 4'd0;
                pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            hold_i_q <= 16'h0000;
            hold_q_q <= 16'h0000;
            step_q   <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            step_q   <= step_d;
            ovr_q    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_fast_square_packer.sv
// Directed and randomized checks of fast_square_packer against a
// word-stream model built from strobe counting.
module tb_fast_square_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_strobe;
    logic        record;
    logic        freq_step;
    logic [15:0] i_word;
    logic [15:0] q_word;
    logic        fifo_full;
    logic        fifo_wr;
    logic [15:0] fifo_data;
    logic [15:0] step_index;
    logic [15:0] overrun_count;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [15:0] wq[$];
    int          ws[$];
    logic [15:0] eq[$];
    int          capc[$];
    int          rd    = 0;
    int          mcnt  = 0;

    fast_square_packer #(
        .MARKER(16'h8000),
        .CNT_W (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_strobe(sample_strobe),
        .record       (record),
        .freq_step    (freq_step),
        .i_word       (i_word),
        .q_word       (q_word),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .step_index   (step_index),
        .overrun_count(overrun_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fifo_wr === 1'b1) begin
            wq.push_back(fifo_data);
            ws.push_back(cyc);
        end
    end

    function automatic logic [15:0] esc(input logic [15:0] w);
        return (w == 16'h8000) ? 16'h8001 : w;
    endfunction

    function automatic logic [15:0] rw();
        return ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom());
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        sample_strobe = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic strobes(input int n, input bit cap, input bit fix = 1'b0,
                           input logic [15:0] fi = 16'h0,
                           input logic [15:0] fq = 16'h0);
        logic [15:0] iw, qw;
        bit          got;
        for (int k = 0; k < n; k++) begin
            iw  = (fix && mcnt == 15) ? fi : rw();
            qw  = (fix && mcnt == 15) ? fq : rw();
            got = (mcnt == 15) && cap;
            if (got) begin
                eq.push_back(esc(iw));
                eq.push_back(esc(qw));
            end
            i_word        = iw;
            q_word        = qw;
            sample_strobe = 1'b1;
            mcnt          = (mcnt + 1) % 16;
            tick();
            if (got) capc.push_back(cyc);
        end
        sample_strobe = 1'b0;
    endtask

    task automatic hdr(input logic [15:0] idx);
        eq.push_back(16'h8000);
        eq.push_back(idx);
    endtask

    task automatic chk_writes(input string tag);
        int n;
        n = wq.size() - rd;
        chk({tag, ".count"}, n, eq.size());
        for (int k = 0; k < eq.size(); k++)
            chk($sformatf("%s.w%0d", tag, k),
                (k < n) ? {16'h0, wq[rd + k]} : 32'hFFFF_FFFF, {16'h0, eq[k]});
        rd = wq.size();
        eq.delete();
        capc.delete();
    endtask

    initial begin
        int c;
        reset         = 1'b1;
        sample_strobe = 1'b0;
        record        = 1'b0;
        freq_step     = 1'b0;
        i_word        = 16'h0;
        q_word        = 16'h0;
        fifo_full     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.wr", fifo_wr, 1'b0);
        chk("rst.data", fifo_data, 16'h0);
        chk("rst.step", step_index, 16'h0);
        chk("rst.ovr", overrun_count, 16'h0);
        idle(2);
        chk("idle.nowrite", wq.size(), 0);

        // basic capture: header then two fixed pairs
        record = 1'b1;
        tick();
        c = cyc;
        mcnt = 0;
        hdr(16'h0000);
        strobes(16, 1'b1, 1'b1, 16'h1234, 16'hABCD);
        strobes(16, 1'b1, 1'b1, 16'h1234, 16'hABCD);
        idle(4);
        chk("t1.mstamp", ws[rd], c);
        chk("t1.xstamp", ws[rd + 1], c + 1);
        chk("t1.istamp", ws[rd + 2], capc[0]);
        chk("t1.qstamp", ws[rd + 3], capc[0] + 1);
        chk_writes("t1");

        // freq_step mid-word
        strobes(7, 1'b1);
        freq_step = 1'b1;
        tick();
        freq_step = 1'b0;
        c = cyc;
        mcnt = 0;
        hdr(16'd1);
        strobes(16, 1'b1);
        idle(4);
        chk("t2a.mstamp", ws[rd], c);
        chk("t2a.xstamp", ws[rd + 1], c + 1);
        chk_writes("t2a");

        // freq_step discards a stalled pending pair
        fifo_full = 1'b1;
        strobes(16, 1'b0);
        freq_step = 1'b1;
        tick();
        freq_step = 1'b0;
        fifo_full = 1'b0;
        mcnt = 0;
        hdr(16'd2);
        strobes(16, 1'b1);
        idle(4);
        chk_writes("t2b");

        // freq_step coincident with the 16th strobe wins
        strobes(15, 1'b1);
        i_word        = 16'h5555;
        q_word        = 16'h6666;
        sample_strobe = 1'b1;
        freq_step     = 1'b1;
        tick();
        freq_step = 1'b0;
        mcnt = 0;
        hdr(16'd3);
        strobes(16, 1'b1);
        idle(4);
        chk("t2c.step", step_index, 16'd3);
        chk("t2c.ovr", overrun_count, 16'd0);
        chk_writes("t2c");

        // escape of a data word equal to the marker
        strobes(16, 1'b1, 1'b1, 16'h8000, 16'h8000);
        idle(4);
        chk_writes("t3");

        // 40 cycles of backpressure: first pair held, second dropped
        fifo_full = 1'b1;
        strobes(16, 1'b1);
        strobes(24, 1'b0);
        chk("t4.stall", wq.size() - rd, 0);
        chk("t4.ovr", overrun_count, 16'd1);
        fifo_full = 1'b0;
        idle(6);
        chk_writes("t4");

        // record falls at count 7, then rises again
        strobes(15, 1'b1);
        record = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_word        = rw();
            q_word        = rw();
            sample_strobe = 1'b1;
            tick();
        end
        idle(3);
        chk_writes("t5a");
        record = 1'b1;
        tick();
        mcnt = 0;
        hdr(16'd3);
        strobes(15, 1'b1);
        idle(3);
        chk("t5.partial", wq.size() - rd, 2);
        strobes(1, 1'b1);
        idle(4);
        chk("t5.step", step_index, 16'd3);
        chk_writes("t5b");

        // random strobe pattern, no backpressure
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 1) strobes(1, 1'b1);
            else idle(1);
        end
        idle(4);
        chk("t6.ovr", overrun_count, 16'd1);
        chk_writes("t6");

        // reset while EMIT_Q is stalled
        strobes(15 - mcnt, 1'b1);
        strobes(1, 1'b1);
        tick();
        fifo_full = 1'b1;
        #1;
        chk("t7.stallwr", fifo_wr, 1'b0);
        chk("t7.qdata", fifo_data, eq[eq.size() - 1]);
        void'(eq.pop_back());
        reset  = 1'b1;
        record = 1'b0;
        tick();
        fifo_full = 1'b0;
        #1;
        chk("t7.wr", fifo_wr, 1'b0);
        chk("t7.data", fifo_data, 16'h0);
        chk("t7.step", step_index, 16'h0);
        chk("t7.ovr", overrun_count, 16'h0);
        reset = 1'b0;
        idle(5);
        chk_writes("t7a");
        record = 1'b1;
        tick();
        mcnt = 0;
        hdr(16'h0000);
        idle(4);
        chk_writes("t7b");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
